// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined control unit.
//   - opcode constants
//   - control-bundle bit positions {WB[1:0], M[2:0], EXE[3:0]}
//   - forwarding-select encodings for fwd_a / fwd_b
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    // Bundle layout: [8:7] WB {memtoreg,regwrite}, [6:4] M {branch,memread,memwrite},
    // [3:0] EXE {regdst,alusrc,rtype,beq}
    localparam int BND_W      = 9;
    localparam int B_MEMTOREG = 8;
    localparam int B_REGWRITE = 7;
    localparam int B_BRANCH   = 6;
    localparam int B_MEMREAD  = 5;
    localparam int B_MEMWRITE = 4;
    localparam int B_REGDST   = 3;
    localparam int B_ALUSRC   = 2;
    localparam int B_RTYPE    = 1;
    localparam int B_BEQ      = 0;
    localparam int WB_LO      = 7;
    localparam int M_HI       = 6;
    localparam int M_LO       = 4;
    localparam int EXE_HI     = 3;

    // EX/MEM keeps only the WB+M part of the bundle
    localparam int CTL_W      = BND_W - M_LO;
    localparam int X_REGWRITE = B_REGWRITE - M_LO;

    localparam int MISC_W     = 6;   // {j,bne,imm,andi,ori,addi}

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Handshake bundle between the ID-stage datapath and the control unit.
//   master: drives the ID-stage instruction fields and ex_flush; observes control outputs
//   slave : the control unit itself
interface pipe_ctrl_unit_if #(
    parameter int OP_W   = 6,
    parameter int RA_W   = 5,
    parameter int SCNT_W = 16
);
    logic              id_valid;
    logic [OP_W-1:0]   id_op;
    logic [RA_W-1:0]   id_rs;
    logic [RA_W-1:0]   id_rt;
    logic [RA_W-1:0]   id_rd;
    logic              ex_flush;

    logic              stall_o;
    logic [3:0]        ex_ctrl;
    logic [5:0]        ex_misc;
    logic [2:0]        mem_ctrl;
    logic [1:0]        wb_ctrl;
    logic [RA_W-1:0]   mem_dst;
    logic [RA_W-1:0]   wb_dst;
    logic              ex_illegal;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [SCNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_op, id_rs, id_rt, id_rd, ex_flush,
        input  stall_o, ex_ctrl, ex_misc, mem_ctrl, wb_ctrl, mem_dst, wb_dst,
               ex_illegal, fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_op, id_rs, id_rt, id_rd, ex_flush,
        output stall_o, ex_ctrl, ex_misc, mem_ctrl, wb_ctrl, mem_dst, wb_dst,
               ex_illegal, fwd_a, fwd_b, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_unit_decode.sv
// ctrl_decode: combinational opcode decoder.
//   valid_i   : ID holds a real instruction (0 -> bubble)
//   op_i      : opcode
//   bnd_o     : {WB,M,EXE} control bundle
//   misc_o    : {j,bne,imm,andi,ori,addi}
//   illegal_o : valid but undecodable opcode
//   uses_rt_o : instruction reads rt as a source (R, sw, beq, bne)
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int OP_W = 6
)(
    input  logic              valid_i,
    input  logic [OP_W-1:0]   op_i,
    output logic [BND_W-1:0]  bnd_o,
    output logic [MISC_W-1:0] misc_o,
    output logic              illegal_o,
    output logic              uses_rt_o
);
    always_comb begin
        bnd_o     = '0;
        misc_o    = '0;
        illegal_o = 1'b0;
        uses_rt_o = 1'b0;
        if (valid_i) begin
            //                         WB  M   EXE
            case (op_i)
                OP_W'(OP_R):    begin bnd_o = 9'b01_000_1010; uses_rt_o = 1'b1; end
                OP_W'(OP_LW):   bnd_o = 9'b11_010_0100;
                OP_W'(OP_SW):   begin bnd_o = 9'b00_001_0100; uses_rt_o = 1'b1; end
                OP_W'(OP_BEQ):  begin bnd_o = 9'b00_100_0001; uses_rt_o = 1'b1; end
                OP_W'(OP_BNE):  begin bnd_o = 9'b00_100_0000; misc_o = 6'b010000; uses_rt_o = 1'b1; end
                OP_W'(OP_J):    misc_o = 6'b100000;
                OP_W'(OP_ADDI): begin bnd_o = 9'b01_000_0100; misc_o = 6'b001001; end
                OP_W'(OP_ANDI): begin bnd_o = 9'b01_000_0100; misc_o = 6'b001100; end
                OP_W'(OP_ORI):  begin bnd_o = 9'b01_000_0100; misc_o = 6'b001010; end
                default:        illegal_o = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined MIPS control. Decodes the ID opcode and carries the control
// bundle through ID/EX, EX/MEM and MEM/WB; generates load-use stall, branch flush bubble,
// $0 write suppression, operand forwarding selects and a saturating stall counter.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : pipe_ctrl_unit_if.slave (ID fields + ex_flush in; control outputs out)
// Build option: define PIPE_CTRL_FWD_EN for EX forwarding. Without it fwd_a/fwd_b stay 00 and
// ID also stalls on any RAW hazard against EX or MEM (WB is covered by a write-first regfile).
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int OP_W   = 6,
    parameter int RA_W   = 5,
    parameter int SCNT_W = 16
)(
    input logic             clk,
    input logic             rst_n,
    pipe_ctrl_unit_if.slave bus
);
    logic [BND_W-1:0]  dec_bnd;
    logic [MISC_W-1:0] dec_misc;
    logic              dec_ill, dec_uses_rt;

    ctrl_decode #(.OP_W(OP_W)) u_dec (
        .valid_i   (bus.id_valid),
        .op_i      (bus.id_op),
        .bnd_o     (dec_bnd),
        .misc_o    (dec_misc),
        .illegal_o (dec_ill),
        .uses_rt_o (dec_uses_rt)
    );

    logic [BND_W-1:0]  idex_bnd_q, idex_bnd_d;
    logic [MISC_W-1:0] idex_misc_q, idex_misc_d;
    logic              idex_ill_q, idex_ill_d;
    logic [RA_W-1:0]   idex_dst_q, idex_dst_d;
    logic [RA_W-1:0]   idex_rt_q, idex_rt_d;
`ifdef PIPE_CTRL_FWD_EN
    logic [RA_W-1:0]   idex_rs_q, idex_rs_d;
`endif
    logic [CTL_W-1:0]  exmem_ctl_q;
    logic [RA_W-1:0]   exmem_dst_q;
    logic [1:0]        memwb_wb_q;
    logic [RA_W-1:0]   memwb_dst_q;
    logic [SCNT_W-1:0] cnt_q, cnt_d;

    logic [RA_W-1:0]   id_dst;
    logic              load_use, raw_haz, stall_raw, kill;

    // A stage holding a nonzero dst with the given write-enable collides with an ID source.
    function automatic logic src_hit(input logic [RA_W-1:0] dst, input logic we,
                                     input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt,
                                     input logic use_rt);
        return we && (dst != '0) && ((dst == rs) || (use_rt && (dst == rt)));
    endfunction

    // For a lw in EX, its rt is the load destination; memread marks it as a load.
    always_comb begin
        load_use = bus.id_valid &&
                   src_hit(idex_rt_q, idex_bnd_q[B_MEMREAD], bus.id_rs, bus.id_rt, dec_uses_rt);
`ifdef PIPE_CTRL_FWD_EN
        raw_haz  = 1'b0;
`else
        raw_haz  = bus.id_valid &&
                   (src_hit(idex_dst_q, idex_bnd_q[B_REGWRITE], bus.id_rs, bus.id_rt, dec_uses_rt) ||
                    src_hit(exmem_dst_q, exmem_ctl_q[X_REGWRITE], bus.id_rs, bus.id_rt, dec_uses_rt));
`endif
        stall_raw = load_use || raw_haz;
        kill      = stall_raw || bus.ex_flush || !bus.id_valid;
    end

    // Flush kills the ID instruction anyway, so holding PC would only lose the redirect.
    assign bus.stall_o = stall_raw && !bus.ex_flush;

    assign id_dst = dec_bnd[B_REGDST] ? bus.id_rd : bus.id_rt;

    always_comb begin
        idex_bnd_d  = dec_bnd;
        idex_misc_d = dec_misc;
        idex_ill_d  = dec_ill;
        idex_dst_d  = id_dst;
        idex_rt_d   = bus.id_rt;
`ifdef PIPE_CTRL_FWD_EN
        idex_rs_d   = bus.id_rs;
`endif
        if (id_dst == '0) idex_bnd_d[B_REGWRITE] = 1'b0;
        if (kill) begin
            idex_bnd_d  = '0;
            idex_misc_d = '0;
            idex_ill_d  = 1'b0;
            idex_dst_d  = '0;
            idex_rt_d   = '0;
`ifdef PIPE_CTRL_FWD_EN
            idex_rs_d   = '0;
`endif
        end
    end

    assign cnt_d = (bus.stall_o && !(&cnt_q)) ? cnt_q + SCNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_bnd_q  <= '0;
            idex_misc_q <= '0;
            idex_ill_q  <= 1'b0;
            idex_dst_q  <= '0;
            idex_rt_q   <= '0;
`ifdef PIPE_CTRL_FWD_EN
            idex_rs_q   <= '0;
`endif
            exmem_ctl_q <= '0;
            exmem_dst_q <= '0;
            memwb_wb_q  <= '0;
            memwb_dst_q <= '0;
            cnt_q       <= '0;
        end else begin
            idex_bnd_q  <= idex_bnd_d;
            idex_misc_q <= idex_misc_d;
            idex_ill_q  <= idex_ill_d;
            idex_dst_q  <= idex_dst_d;
            idex_rt_q   <= idex_rt_d;
`ifdef PIPE_CTRL_FWD_EN
            idex_rs_q   <= idex_rs_d;
`endif
            exmem_ctl_q <= idex_bnd_q[BND_W-1:M_LO];
            exmem_dst_q <= idex_dst_q;
            memwb_wb_q  <= exmem_ctl_q[CTL_W-1:WB_LO-M_LO];
            memwb_dst_q <= exmem_dst_q;
            cnt_q       <= cnt_d;
        end
    end

`ifdef PIPE_CTRL_FWD_EN
    // MEM result is newer than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src,
                                           input logic m_we, input logic [RA_W-1:0] m_dst,
                                           input logic w_we, input logic [RA_W-1:0] w_dst);
        if (m_we && (m_dst != '0) && (m_dst == src)) return FWD_MEM;
        if (w_we && (w_dst != '0) && (w_dst == src)) return FWD_WB;
        return FWD_RF;
    endfunction

    assign bus.fwd_a = fwd_sel(idex_rs_q, exmem_ctl_q[X_REGWRITE], exmem_dst_q,
                               memwb_wb_q[0], memwb_dst_q);
    assign bus.fwd_b = fwd_sel(idex_rt_q, exmem_ctl_q[X_REGWRITE], exmem_dst_q,
                               memwb_wb_q[0], memwb_dst_q);
`else
    assign bus.fwd_a = FWD_RF;
    assign bus.fwd_b = FWD_RF;
`endif

    assign bus.ex_ctrl    = idex_bnd_q[EXE_HI:0];
    assign bus.ex_misc    = idex_misc_q;
    assign bus.ex_illegal = idex_ill_q;
    assign bus.mem_ctrl   = exmem_ctl_q[M_HI-M_LO:0];
    assign bus.mem_dst    = exmem_dst_q;
    assign bus.wb_ctrl    = memwb_wb_q;
    assign bus.wb_dst     = memwb_dst_q;
    assign bus.stall_cnt  = cnt_q;

endmodule
